decoder_scan_rtl: RTL and testbench

Parametrised binary-to-one-hot decoder with a registered output, replacing fixed combinational 3-to-8 decoders. Two operating modes:
- DIRECT: decodes a captured select value under a valid/ready handshake.
- SCAN: autonomously walks the one-hot output across all lines, with a programmable dwell per line.
Used for LED/row/chip-select driving where a glitch-free, registered one-hot bus is required.

---
 rtl/decoder_pkg.sv | 12 +
 rtl/decoder_scan_rtl_onehot_enc.sv | 10 +
 rtl/decoder_scan_rtl.sv | 72 +++++++
 tb/tb_decoder_scan_rtl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state, mode constants and width helper for the one-hot decoder
package decoder_pkg;
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/decoder_scan_rtl_onehot_enc.sv
// onehot_enc: combinational index to one-hot, all zeros when the index is out of range
module onehot_enc #(
    parameter int IW = 3,
    parameter int OW = 8
) (
    input  logic [IW-1:0] idx,
    output logic [OW-1:0] y
);
    assign y = (int'(idx) < OW) ? OW'(1) << idx : '0;
endmodule

// File: rtl/decoder_scan_rtl.sv
// decoder_scan_rtl: registered one-hot decoder with handshake-driven DIRECT mode and autonomous SCAN mode
module decoder_scan_rtl
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    output logic             sel_ready,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic [SEL_W-1:0] idx,
    output logic             err
);
    localparam int CW = clog2(DWELL) < 1 ? 1 : clog2(DWELL);
    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic [SEL_W-1:0] nidx;
    logic [OUT_W-1:0] enc;
    logic accept, enter_scan, last, wrap;
    assign sel_ready  = state == DIRECT;
    assign state_d    = !en ? IDLE : (mode == MODE_SCAN ? SCAN : DIRECT);
    // a mode change or en drop outranks an accept offered in the same cycle
    assign accept     = sel_valid && sel_ready && state_d == DIRECT;
    assign enter_scan = state_d == SCAN && state != SCAN;
    assign last       = cnt == CW'(DWELL - 1);
    assign wrap       = idx == SEL_W'(OUT_W - 1);
    // one encoder serves both paths: accepted sel, scan restart, or next scan line
    assign nidx = accept ? sel : (enter_scan || wrap) ? '0 : idx + SEL_W'(1);
    onehot_enc #(.IW(SEL_W), .OW(OUT_W)) u_enc (.idx(nidx), .y(enc));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            idx     <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_d;
            err   <= 1'b0;
            if (state_d == IDLE) begin
                cnt     <= '0;
                y       <= '0;
                y_valid <= 1'b0;
                idx     <= '0;
            end else if (enter_scan) begin
                cnt     <= '0;
                y       <= enc;
                y_valid <= 1'b1;
                idx     <= nidx;
            end else if (state_d == SCAN) begin
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    y   <= enc;
                    idx <= nidx;
                end
            end else if (accept) begin
                y       <= enc;
                idx     <= sel;
                y_valid <= |enc;
                err     <= ~|enc;
            end
        end
    end
endmodule

// File: tb/tb_decoder_scan_rtl.sv
// tb_decoder_scan_rtl: scoreboard bench for two decoder configurations driven by shared stimulus
module tb_decoder_scan_rtl;
    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, mode = 1'b0, sel_valid = 1'b0;
    logic [2:0] sel = 3'd0;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic       v;
        logic [2:0] idx;
        logic       err;
        logic       rdy;
    } exp_t;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int OW = g ? 6 : 8;
        localparam int DW = g ? 1 : 4;
        logic [OW-1:0] y;
        logic y_valid, err, sel_ready;
        logic [2:0] idx;
        exp_t q[$];
        exp_t cur, e, got;
        bit active, scanning;
        int age;

        decoder_scan_rtl #(.SEL_W(3), .OUT_W(OW), .DWELL(DW)) dut (
            .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
            .sel_ready(sel_ready), .y(y), .y_valid(y_valid), .idx(idx), .err(err)
        );

        assign got = {8'(y), y_valid, idx, err, sel_ready};

        always @(negedge rst_n) begin
            cur = '0; active = 0; scanning = 0; age = 0;
            #1;
            vectors++;
            if (got !== exp_t'(0)) begin
                miscompares++;
                $display("FAIL u%0d async_reset t=%0t got y=%h v=%b idx=%0d err=%b rdy=%b want all zero",
                         g, $time, got.y, got.v, got.idx, got.err, got.rdy);
            end
        end

        // reference: scan line is elapsed cycles since entry divided by the dwell, modulo line count
        always @(posedge clk) begin
            if (!rst_n || !en) begin
                cur = '0; active = 0; scanning = 0; age = 0;
            end else if (mode) begin
                age = (active && scanning) ? age + 1 : 0;
                scanning = 1; active = 1;
                cur.idx = 3'((age / DW) % OW);
                cur.y = 8'(1) << ((age / DW) % OW);
                cur.v = 1'b1; cur.err = 1'b0; cur.rdy = 1'b0;
            end else begin
                cur.err = 1'b0;
                if (active && !scanning && sel_valid) begin
                    cur.idx = sel;
                    cur.err = int'(sel) >= OW;
                    cur.v = int'(sel) < OW;
                    cur.y = int'(sel) < OW ? 8'(1) << sel : 8'h00;
                end
                scanning = 0; active = 1; cur.rdy = 1'b1;
            end
            q.push_back(cur);
        end

        always @(posedge clk) begin
            #1;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL u%0d scoreboard_underflow t=%0t", g, $time);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL u%0d cycle t=%0t got y=%h v=%b idx=%0d err=%b rdy=%b want y=%h v=%b idx=%0d err=%b rdy=%b",
                             g, $time, got.y, got.v, got.idx, got.err, got.rdy, e.y, e.v, e.idx, e.err, e.rdy);
                end
            end
        end
    end

    task automatic step(input logic e, input logic m, input logic v, input logic [2:0] s);
        @(negedge clk);
        en = e; mode = m; sel_valid = v; sel = s;
    endtask

    logic m_r;
    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 3'(i));
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 6);
        step(1, 0, 1, 5);
        step(1, 0, 0, 0);
        repeat (40) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        repeat (15) step(1, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        repeat (10) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 2);
        step(1, 1, 1, 5);
        repeat (3) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 3);
        step(1, 0, 0, 0);
        repeat (5) step(1, 1, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_r = 1'b0;
        repeat (3000) begin
            if ($urandom_range(19) == 0) m_r = ~m_r;
            step($urandom_range(9) != 0, m_r, 1'($urandom), 3'($urandom));
        end
        step(0, 0, 0, 0);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
